pipelined_rca: RTL and testbench
================================

# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor for wide datapaths. The operand width is split into STAGES equal segments, each a ripple chain of full adders, with the inter-segment carry registered so the critical path is WIDTH/STAGES bit-cells long. A valid/ready handshake on both sides allows the block to sit between streaming producers and consumers. It sustains one operation per cycle when not stalled.

## Interface
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH); segment width SEG = WIDTH/STAGES.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (ignored when in_sub=1).
- in_sub  input  1  1 = A − B, 0 = A + B + cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of MSB (subtract: 1 = no borrow).
- out_ovf  output  1  signed overflow (only with PIPE_RCA_OVF_EN).

## Operation
- Effective B = in_sub ? ~in_b : in_b; effective carry-in = in_sub ? 1 : in_cin.
- Pipeline register bank k (1..STAGES) holds: valid bit, sum bits for segments 0..k−1, registered carry out of segment k−1, operand bits for segments k..STAGES−1 (B already conditioned).
- Segment k−1 computed combinationally from bank k−1 operands and carry; bank 0 = input ports.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All banks load when adv=1, hold when adv=0.
- Bank 1 valid loads in_valid && in_ready; each later bank valid loads previous valid. Bubbles are not collapsed; they travel with the data.
- Output: out_sum, out_cout, out_valid taken directly from bank STAGES. Result modulo 2^WIDTH; carry out is bit WIDTH of the full sum.
- Beats leave in acceptance order; none dropped or duplicated.
- STAGES=1: single registered full-width ripple adder, same handshake.

## Timing
- Reset: all valid bits 0, all data/carry registers 0; out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1 in the cycle after reset deasserts.
- rst has priority over any concurrent transfer; a beat presented with rst=1 is discarded. Reset mid-flight discards all in-flight beats.
- Latency: beat accepted in cycle n appears with out_valid=1 in cycle n+STAGES when no stall occurs; each stall cycle adds one.
- Throughput: 1 beat/cycle with out_ready held high.
- out_valid=1 && out_ready=0: out_sum/out_cout/out_ovf and out_valid held stable; in_ready=0; no beat accepted.
- Simultaneous output drain and input accept in same cycle is legal and required.
- in_valid=0 while in_ready=1: bubble enters; outputs of a bubble slot are don't-care but out_valid=0.
- Combinational path per cycle: SEG full-adder cells plus B-conditioning XOR in bank 0 only.

## Configuration
- PIPE_RCA_OVF_EN defined: carry into MSB registered alongside the final segment; out_ovf = carry_into_MSB XOR out_cout, valid with out_valid, held under stall.
- Not defined: no extra register; out_ovf tied to 0.

## Test plan
- WIDTH=32, STAGES=4: in_a=0xFFFFFFFF, in_b=0x00000001, cin=0, add -> out_sum=0x00000000, out_cout=1, out_valid exactly 4 cycles after accept (carry crosses all three stage boundaries).
- Subtract: in_a=5, in_b=7 -> out_sum=0xFFFFFFFE, out_cout=0; in_a=7, in_b=5 -> out_sum=2, out_cout=1; in_cin=1 ignored in both.
- PIPE_RCA_OVF_EN on: 0x7FFFFFFF+1 -> out_sum=0x80000000, out_ovf=1, out_cout=0; 0x80000000−1 -> 0x7FFFFFFF, out_ovf=1; 3+4 -> out_ovf=0. Macro off: out_ovf=0 for all.
- Back-pressure: stream 6 beats (a=i, b=0x100*i) with out_ready low for cycles 5–7 -> in_ready low during those cycles, outputs stable, all 6 sums 0x101*i delivered in order, no loss.
- Back-to-back: 32 random beats, out_ready=1 -> one result per cycle, each matches a+b+cin mod 2^32 with correct cout.
- Reset mid-flight: 3 beats in flight, rst for 1 cycle -> out_valid=0 and out_sum=0 next cycle, none of the 3 beats ever emerges; STAGES=1 and STAGES=32 builds pass the first two scenarios.

Source files
------------

// File: rtl/pipelined_rca.sv
// pipelined_rca: segmented pipelined ripple-carry add/sub; define PIPE_RCA_OVF_EN to register signed overflow on out_ovf
module pipelined_rca #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int SEG = WIDTH / STAGES;
    function automatic int boff(input int k);
        int r;
        r = 0;
        for (int j = 0; j < k; j++) r += WIDTH - j * SEG;
        return r;
    endfunction
    localparam int BT = boff(STAGES);
    logic [WIDTH-1:0] w [STAGES+1];
    logic             c [STAGES+1];
    logic             v [STAGES+1];
    logic [BT-1:0]    bbus;
    logic             adv;
    assign adv               = !out_valid || out_ready;
    assign in_ready          = adv;
    assign w[0]              = in_a;
    assign c[0]              = in_sub | in_cin;
    assign v[0]              = in_valid;
    assign bbus[WIDTH-1:0]   = in_sub ? ~in_b : in_b;
    assign out_valid         = v[STAGES];
    assign out_sum           = w[STAGES];
    assign out_cout          = c[STAGES];
    for (genvar s = 0; s < STAGES; s++) begin : g
        localparam int BW = WIDTH - s * SEG;
        logic [BW-1:0]    bi;
        logic [SEG-1:0]   sa;
        logic [SEG-1:0]   ss;
        logic [SEG:0]     cc;
        logic [WIDTH-1:0] nw;
        logic [WIDTH-1:0] wr;
        logic             cr;
        logic             vr;
        assign bi = bbus[boff(s) +: BW];
        assign sa = w[s][s*SEG +: SEG];
        always_comb begin
            cc = {{SEG{1'b0}}, c[s]};
            ss = '0;
            for (int i = 0; i < SEG; i++) begin
                ss[i]   = sa[i] ^ bi[i] ^ cc[i];
                cc[i+1] = (sa[i] & bi[i]) | (cc[i] & (sa[i] ^ bi[i]));
            end
            nw = w[s];
            nw[s*SEG +: SEG] = ss;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                wr <= '0;
                cr <= 1'b0;
                vr <= 1'b0;
            end else if (adv) begin
                wr <= nw;
                cr <= cc[SEG];
                vr <= v[s];
            end
        end
        assign w[s+1] = wr;
        assign c[s+1] = cr;
        assign v[s+1] = vr;
        if (s < STAGES - 1) begin : gb
            logic [BW-SEG-1:0] br;
            always_ff @(posedge clk) begin
                if (rst) br <= '0;
                else if (adv) br <= bi[BW-1:SEG];
            end
            assign bbus[boff(s+1) +: BW-SEG] = br;
        end else begin : go
`ifdef PIPE_RCA_OVF_EN
            logic cm;
            always_ff @(posedge clk) begin
                if (rst) cm <= 1'b0;
                else if (adv) cm <= cc[SEG-1];
            end
            assign out_ovf = cm ^ cr;
`else
            assign out_ovf = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: vector table, back-pressure, random streaming and reset-flush checks against an arithmetic model
module tb_pipelined_rca;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef PIPE_RCA_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    int total = 0;
    int bad = 0;
    int npop = 0;
    int run = 0;
    int maxrun = 0;
    logic [33:0] exp_q [$];

    pipelined_rca #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // returns {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint u, r;
        logic [31:0] s;
        logic co, ov;
        if (sub) begin
            s  = a - b;
            co = a >= b;
            r  = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u  = longint'(a) + longint'(b) + longint'(cin);
            s  = u[31:0];
            co = u[32];
            r  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        ov = OVF && (r > 64'sd2147483647 || r < -64'sd2147483648);
        return {ov, co, s};
    endfunction

    logic        stall = 1'b0;
    logic        prev_pop = 1'b0;
    logic [31:0] hs;
    logic        hc, ho;
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst) begin
            exp_q.delete();
            stall = 1'b0;
            prev_pop = 1'b0;
            run = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, hs);
                chk("hold_cout", out_cout, hc);
                chk("hold_ovf", out_ovf, ho);
            end
            stall = out_valid && !out_ready;
            hs = out_sum; hc = out_cout; ho = out_ovf;
            if (out_valid && out_ready) begin
                npop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out got sum=%0h want no beat", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", out_sum, e[31:0]);
                    chk("cout", out_cout, e[32]);
                    chk("ovf", out_ovf, e[33]);
                end
                run = prev_pop ? run + 1 : 1;
                if (run > maxrun) maxrun = run;
            end else run = 0;
            prev_pop = out_valid && out_ready;
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] s;
        logic        co, ov;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int lat, idx, p0;
        logic acc;
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{32'd7,         32'd5,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'd3,         32'd4,         1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[7] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};

        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_a = tbl[k].a; in_b = tbl[k].b; in_cin = tbl[k].cin; in_sub = tbl[k].sub;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("vec_latency", lat, STAGES);
            chk("vec_sum", out_sum, tbl[k].s);
            chk("vec_cout", out_cout, tbl[k].co);
            chk("vec_ovf", out_ovf, tbl[k].ov & OVF);
        end
        repeat (STAGES + 2) tick();

        p0 = npop;
        idx = 0;
        for (int cy = 0; cy < 30; cy++) begin
            out_ready = !(cy >= 5 && cy <= 7);
            in_valid = idx < 6;
            in_a = idx; in_b = 32'h100 * idx; in_cin = 1'b0; in_sub = 1'b0;
            #1;
            if (cy >= 5 && cy <= 7) chk("bp_in_ready", in_ready, 0);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        chk("bp_accepted", idx, 6);
        chk("bp_delivered", npop - p0, 6);

        maxrun = 0;
        for (int k = 0; k < 32; k++) begin
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
            #1;
            chk("b2b_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("b2b_drain", exp_q.size(), 0);
        chk("b2b_run", maxrun, 32);

        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a = 32'h1000 + k; in_b = 32'h22; in_cin = 1'b0; in_sub = 1'b0;
            tick();
        end
        rst = 1'b1;
        in_a = 32'hDEAD;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_sum", out_sum, 0);
        chk("flush_cout", out_cout, 0);
        p0 = npop;
        repeat (STAGES + 6) tick();
        chk("flush_none", npop - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
